mano_exec_ctrl: RTL and testbench
=================================

# mano_exec_ctrl

Run/halt/single-step execution controller for the Mano computer datapath. It owns the datapath clock-enable and the core clear pulse, and loads programs into the 16x8 RAM through a valid/ready port while the core is idle. It counts retired instructions and stops the core on a halt request, on an instruction limit, or when an instruction fails to complete (watchdog). It sits between the top-level `mano_all` wrapper and the external test/debug host.

## Interface

Parameters:
- `ICNT_W`, default 8: width of the retired-instruction counter and of `instr_limit`.
- `WDOG`, default 16: maximum enabled cycles allowed per instruction before a fault is declared (range 2..255).

Ports:
- `CLK`, in, 1: sole clock, rising edge.
- `RST_N`, in, 1: asynchronous active-low reset.
- `start`, in, 1: level; begins free-run from IDLE or HALTED.
- `step`, in, 1: level; executes exactly one instruction from IDLE or HALTED.
- `halt_req`, in, 1: single-cycle pulse, captured into a sticky flag.
- `clear`, in, 1: from HALTED or FAULT, return to IDLE and pulse `core_clr`.
- `instr_done`, in, 1: core's SC-clear (CLRSC); marks the last T-state of an instruction.
- `instr_limit`, in, ICNT_W: stop after this many retired instructions in RUN; 0 means unlimited.
- `ld_valid`, in, 1: loader write request.
- `ld_addr`, in, 4: loader RAM address.
- `ld_data`, in, 8: loader RAM data.
- `ld_ready`, out, 1: loader request accepted this cycle when high together with `ld_valid`.
- `mem_we`, out, 1: RAM write strobe.
- `mem_addr`, out, 4: RAM write address.
- `mem_wdata`, out, 8: RAM write data.
- `cpu_en`, out, 1: datapath clock-enable (gates SC, PC, AR, IR, DR, AC updates).
- `core_clr`, out, 1: one-cycle pulse clearing SC and PC.
- `halted`, out, 1: high in HALTED.
- `fault`, out, 1: high in FAULT.
- `instr_cnt`, out, ICNT_W: retired instructions since the last `core_clr`; wraps modulo 2^ICNT_W.

## Operation

States: IDLE, RUN, STEP, HALTED, FAULT.

- **IDLE**
  - `cpu_en`=0, `ld_ready`=1 except in the cycle after an acceptance.
  - Acceptance registers `mem_addr`/`mem_wdata` and asserts `mem_we` for exactly one cycle, the following cycle. Maximum rate is one write per 2 cycles.
  - `start` goes to RUN; `step` goes to STEP. When both are high, `start` wins.
  - `start`/`step` are not accepted during the `mem_we` cycle.
- **RUN**
  - `cpu_en`=1.
  - On `instr_done` with `cpu_en`=1: `instr_cnt` increments.
  - Go to HALTED if the halt flag is set, or if `instr_limit`≠0 and the incremented count equals `instr_limit`. Otherwise stay in RUN.
- **STEP**
  - `cpu_en`=1 until the first `instr_done`, then `instr_cnt` increments and the state goes to HALTED.
- **HALTED**
  - `cpu_en`=0; the halt flag is cleared on entry.
  - `start` goes to RUN, `step` goes to STEP.
  - `clear` goes to IDLE with a `core_clr` pulse and `instr_cnt` reset to 0.
  - Priority: `clear` > `start` > `step`.
- **FAULT**
  - Entered from RUN/STEP when the watchdog counter reaches `WDOG` without `instr_done`.
  - `cpu_en`=0, `fault`=1. Only `clear` exits (to IDLE, with `core_clr`).
- **Halt flag**
  - Set by `halt_req` in any state except IDLE.
  - Cleared on entering HALTED, IDLE or FAULT.
  - `halt_req` in the same cycle as `instr_done` halts after that instruction.
- **Watchdog**
  - Counts enabled cycles and resets to 0 on `instr_done` and on leaving RUN/STEP.
  - `instr_done` on the cycle the watchdog would expire takes priority: no fault.
- **Ignored inputs**
  - `instr_done` while `cpu_en`=0.
  - `ld_valid` outside IDLE: `ld_ready`=0, no write.

## Timing

- All state, counters and outputs are registered on `CLK`.
- **Reset** (any time, including mid-instruction or mid-write):
  - State goes to IDLE.
  - `cpu_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_clr`=0, `halted`=0, `fault`=0, `instr_cnt`=0.
  - Halt flag and watchdog are cleared.
  - `ld_ready`=1 from the first edge after `RST_N` rises.
  - An in-flight write is dropped.
- `cpu_en` rises the cycle after `start`/`step` is sampled.
- `cpu_en` falls the cycle after the terminating `instr_done` is sampled, so the core executes exactly through the `instr_done` T-state.
- `core_clr` is high for the single cycle after `clear` is sampled, coincident with the IDLE entry.
- `instr_cnt` updates on the same edge that samples `instr_done`.

## Structure

- Shared package `mano_pkg`:
  - state enum `exec_state_t` (IDLE=0, RUN=1, STEP=2, HALTED=3, FAULT=4);
  - `MANO_AW`=4, `MANO_DW`=8.
- One sub-module, `mano_ram_loader`, implements the valid/ready register stage and the `mem_we` pulse, gated by an `idle` input.
- The top-level FSM, watchdog and counter stay in `mano_exec_ctrl`.

## Test plan

1. **Load:** write 0x0C@0, 0x13@1, 0x24@2 with `ld_valid` held high -> `ld_ready` alternates 1,0; three single-cycle `mem_we` pulses with matching addresses/data; `cpu_en` stays 0.
2. **Step:** `step` from IDLE; `instr_done` after 6 enabled cycles -> `cpu_en` high for exactly 6 cycles; `instr_cnt`=1; `halted`=1.
3. **Limit:** `instr_limit`=3, `start`, `instr_done` every 4 cycles -> HALTED after the third `instr_done`; `instr_cnt`=3; `cpu_en`=0 next cycle.
4. **Halt collision:** RUN with `halt_req` pulsed in the same cycle as `instr_done` -> HALTED immediately after; `halt_req` mid-instruction -> completes the instruction, then HALTED.
5. **Watchdog:** RUN, no `instr_done` for 16 enabled cycles (`WDOG`=16) -> FAULT; `start` ignored; `clear` -> IDLE with one `core_clr` pulse and `instr_cnt`=0. Also: `instr_done` on the 16th cycle -> no fault.
6. **Reset:** deassert `RST_N` mid-RUN and during a `mem_we` cycle -> all outputs at reset values asynchronously; no write issued after release.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared definitions for the Mano execution controller slice.
//   MANO_AW / MANO_DW : program RAM address / data widths (16 x 8).
//   exec_state_t      : controller state encoding.
//   is_active()       : true in the states where the datapath is clocked.
package mano_pkg;

    localparam int MANO_AW = 4;
    localparam int MANO_DW = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } exec_state_t;

    function automatic logic is_active(input exec_state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/mano_ram_loader.sv
// Valid/ready program loader for the 16x8 Mano RAM.
//   CLK, RST_N           : clock, asynchronous active-low reset.
//   idle                 : controller will be in IDLE after this edge.
//   ld_valid/addr/data   : host write request.
//   ld_ready             : request accepted when high together with ld_valid.
//   mem_we/addr/wdata    : registered one-cycle RAM write.
// An accepted request drops ld_ready for one cycle, so writes are issued
// at most every other cycle and the mem_we cycle is always visible to the
// controller before the next acceptance.
module mano_ram_loader
    import mano_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               idle,
    input  logic               ld_valid,
    input  logic [MANO_AW-1:0] ld_addr,
    input  logic [MANO_DW-1:0] ld_data,
    output logic               ld_ready,
    output logic               mem_we,
    output logic [MANO_AW-1:0] mem_addr,
    output logic [MANO_DW-1:0] mem_wdata
);

    logic               ld_ready_q, ld_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [MANO_AW-1:0] mem_addr_q, mem_addr_d;
    logic [MANO_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic               accept;

    always_comb begin
        accept      = ld_valid && ld_ready_q;
        // Ready is a flop so it is low throughout reset and only rises on
        // the first edge after release.
        ld_ready_d  = idle && !accept;
        mem_we_d    = accept;
        mem_addr_d  = accept ? ld_addr : mem_addr_q;
        mem_wdata_d = accept ? ld_data : mem_wdata_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ld_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ld_ready_q  <= ld_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ld_ready  = ld_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: rtl/mano_exec_ctrl.sv
// Run/halt/single-step execution controller for the Mano datapath.
//   CLK, RST_N            : clock, asynchronous active-low reset.
//   start, step           : begin free-run / single instruction (levels).
//   halt_req              : pulse, stops RUN at the next instruction boundary.
//   clear                 : leave HALTED/FAULT for IDLE with a core_clr pulse.
//   instr_done            : last T-state of an instruction (core CLRSC).
//   instr_limit           : RUN stops after this many retirements, 0 = none.
//   ld_*                  : program loader port, only ready in IDLE.
//   mem_*                 : RAM write port.
//   cpu_en, core_clr      : datapath clock-enable and SC/PC clear pulse.
//   halted, fault         : state indications.
//   instr_cnt             : instructions retired since the last core_clr.
// All outputs are registered from the next-state decode, so they change on
// the same edge as the state they describe.
module mano_exec_ctrl
    import mano_pkg::*;
#(
    parameter int ICNT_W = 8,
    parameter int WDOG   = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               step,
    input  logic               halt_req,
    input  logic               clear,
    input  logic               instr_done,
    input  logic [ICNT_W-1:0]  instr_limit,
    input  logic               ld_valid,
    input  logic [MANO_AW-1:0] ld_addr,
    input  logic [MANO_DW-1:0] ld_data,
    output logic               ld_ready,
    output logic               mem_we,
    output logic [MANO_AW-1:0] mem_addr,
    output logic [MANO_DW-1:0] mem_wdata,
    output logic               cpu_en,
    output logic               core_clr,
    output logic               halted,
    output logic               fault,
    output logic [ICNT_W-1:0]  instr_cnt
);

    localparam int WD_W = 8;

    exec_state_t       state_q, state_d;
    logic              cpu_en_q, cpu_en_d;
    logic              core_clr_q, core_clr_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              halt_flag_q, halt_flag_d;
    logic [ICNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [ICNT_W-1:0] cnt_inc;
    logic              wdog_expire;
    logic              stop_req;
    logic              entering_rest;

    mano_ram_loader u_loader (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .idle      (state_d == IDLE),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    always_comb begin
        state_d     = state_q;
        instr_cnt_d = instr_cnt_q;
        core_clr_d  = 1'b0;
        cnt_inc     = instr_cnt_q + 1'b1;
        // wdog_q holds the number of enabled cycles already completed, so
        // the current cycle is the last allowed one when it reads WDOG-1.
        wdog_expire = (wdog_q == WD_W'(WDOG - 1));
        // A halt_req coincident with instr_done still stops after it.
        stop_req    = halt_flag_q || halt_req ||
                      ((instr_limit != '0) && (cnt_inc == instr_limit));

        case (state_q)
            IDLE: begin
                // Hold off start/step while a RAM write is on the bus.
                if (!mem_we) begin
                    if (start)     state_d = RUN;
                    else if (step) state_d = STEP;
                end
            end
            RUN: begin
                if (instr_done) begin
                    instr_cnt_d = cnt_inc;
                    if (stop_req) state_d = HALTED;
                end else if (wdog_expire) begin
                    state_d = FAULT;
                end
            end
            STEP: begin
                if (instr_done) begin
                    instr_cnt_d = cnt_inc;
                    state_d     = HALTED;
                end else if (wdog_expire) begin
                    state_d = FAULT;
                end
            end
            HALTED: begin
                if (clear) begin
                    state_d     = IDLE;
                    core_clr_d  = 1'b1;
                    instr_cnt_d = '0;
                end else if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            FAULT: begin
                if (clear) begin
                    state_d     = IDLE;
                    core_clr_d  = 1'b1;
                    instr_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts only while staying inside RUN/STEP; any retirement or exit
        // restarts it.
        wdog_d = (is_active(state_q) && is_active(state_d) && !instr_done) ?
                 wdog_q + 1'b1 : '0;

        entering_rest = (state_d != state_q) &&
                        (state_d inside {IDLE, HALTED, FAULT});
        if (entering_rest)
            halt_flag_d = 1'b0;
        else if (halt_req && (state_q != IDLE))
            halt_flag_d = 1'b1;
        else
            halt_flag_d = halt_flag_q;

        cpu_en_d = is_active(state_d);
        halted_d = (state_d == HALTED);
        fault_d  = (state_d == FAULT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cpu_en_q    <= 1'b0;
            core_clr_q  <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            halt_flag_q <= 1'b0;
            instr_cnt_q <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            core_clr_q  <= core_clr_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            halt_flag_q <= halt_flag_d;
            instr_cnt_q <= instr_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign core_clr  = core_clr_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mano_exec_ctrl.sv
// Self-checking bench for mano_exec_ctrl: a table of per-cycle vectors
// followed by hand-written multi-cycle sequences. Loader writes are checked
// through a scoreboard queue filled when an accepted request is driven.
module tb_mano_exec_ctrl;

    typedef struct packed {
        logic       start, step, halt_req, clear, instr_done, ld_valid;
        logic [3:0] addr;
        logic [7:0] data;
    } ins_t;

    typedef struct packed {
        logic       ld_ready, mem_we, cpu_en, core_clr, halted, fault;
        logic [7:0] cnt;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       start = 0, step = 0, halt_req = 0, clear = 0, instr_done = 0;
    logic [7:0] instr_limit = 8'd0;
    logic       ld_valid = 0;
    logic [3:0] ld_addr = 4'd0;
    logic [7:0] ld_data = 8'd0;
    logic       ld_ready, mem_we, cpu_en, core_clr, halted, fault;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] instr_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_ready_prev = 1'b0;
    wr_t  wr_q[$];
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    mano_exec_ctrl #(.ICNT_W(8), .WDOG(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .step       (step),
        .halt_req   (halt_req),
        .clear      (clear),
        .instr_done (instr_done),
        .instr_limit(instr_limit),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_en     (cpu_en),
        .core_clr   (core_clr),
        .halted     (halted),
        .fault      (fault),
        .instr_cnt  (instr_cnt)
    );

    function automatic ins_t mk_in(input bit s, input bit st, input bit h,
                                   input bit c, input bit d);
        ins_t r;
        r = '0;
        r.start = s; r.step = st; r.halt_req = h; r.clear = c; r.instr_done = d;
        return r;
    endfunction

    function automatic ins_t mk_ld(input logic [3:0] a, input logic [7:0] dd);
        ins_t r;
        r = '0;
        r.ld_valid = 1'b1; r.addr = a; r.data = dd;
        return r;
    endfunction

    function automatic outs_t mk_out(input bit r, input bit we, input bit en,
                                     input bit cl, input bit ha, input bit fa,
                                     input logic [7:0] n);
        outs_t o;
        o.ld_ready = r; o.mem_we = we; o.cpu_en = en; o.core_clr = cl;
        o.halted = ha; o.fault = fa; o.cnt = n;
        return o;
    endfunction

    function automatic outs_t cur_outs();
        return {ld_ready, mem_we, cpu_en, core_clr, halted, fault, instr_cnt};
    endfunction

    task automatic add(input ins_t i, input outs_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    task automatic check_outs(input string tag, input outs_t e);
        outs_t a;
        a = cur_outs();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: outputs {ready,we,en,clr,halted,fault,cnt} got %h want %h",
                     tag, a, e);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs after the edge.
    task automatic cycle(input string tag, input ins_t i, input outs_t e);
        start = i.start; step = i.step; halt_req = i.halt_req; clear = i.clear;
        instr_done = i.instr_done; ld_valid = i.ld_valid;
        ld_addr = i.addr; ld_data = i.data;
        if (i.ld_valid && exp_ready_prev)
            wr_q.push_back({i.addr, i.data});
        @(posedge CLK);
        #1;
        check_outs(tag, e);
        if (mem_we) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s: unexpected write addr=%h data=%h, none expected",
                         tag, mem_addr, mem_wdata);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== {w.a, w.d}) begin
                    n_bad++;
                    $display("FAIL %s: write got addr=%h data=%h want addr=%h data=%h",
                             tag, mem_addr, mem_wdata, w.a, w.d);
                end
                $display("%s write addr=%h data=%h", tag, mem_addr, mem_wdata);
            end
        end
        exp_ready_prev = e.ld_ready;
        $display("%s in=%h out=%h", tag, i, cur_outs());
    endtask

    // Assert reset asynchronously, check, hold across an edge, release.
    task automatic do_reset(input string tag);
        start = 0; step = 0; halt_req = 0; clear = 0; instr_done = 0; ld_valid = 0;
        RST_N = 1'b0;
        #2;
        check_outs({tag, "_async"}, mk_out(0, 0, 0, 0, 0, 0, 8'd0));
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 12'h000) begin
            n_bad++;
            $display("FAIL %s_bus: mem addr/data got %h want 000", tag, {mem_addr, mem_wdata});
        end
        @(posedge CLK);
        #1;
        check_outs({tag, "_held"}, mk_out(0, 0, 0, 0, 0, 0, 8'd0));
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        exp_ready_prev = 1'b0;
        $display("%s reset released", tag);
    endtask

    initial begin
        ins_t  nop;
        nop = mk_in(0, 0, 0, 0, 0);

        // Load, step, priorities, halt collision.
        add(nop,                 mk_out(1, 0, 0, 0, 0, 0, 8'd0));
        add(mk_ld(0, 8'h0C),     mk_out(0, 1, 0, 0, 0, 0, 8'd0));
        add(mk_ld(1, 8'h13),     mk_out(1, 0, 0, 0, 0, 0, 8'd0));
        add(mk_ld(1, 8'h13),     mk_out(0, 1, 0, 0, 0, 0, 8'd0));
        add(mk_ld(2, 8'h24),     mk_out(1, 0, 0, 0, 0, 0, 8'd0));
        add(mk_ld(2, 8'h24),     mk_out(0, 1, 0, 0, 0, 0, 8'd0));
        add(nop,                 mk_out(1, 0, 0, 0, 0, 0, 8'd0));
        add(mk_ld(3, 8'h5A),     mk_out(0, 1, 0, 0, 0, 0, 8'd0));
        add(mk_in(1, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 8'd0)); // start during mem_we
        add(mk_in(0, 1, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 8'd0)); // step
        add(nop,                 mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        add(mk_ld(5, 8'hFF),     mk_out(0, 0, 1, 0, 0, 0, 8'd0)); // load outside IDLE
        add(nop,                 mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        add(nop,                 mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        add(nop,                 mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        add(mk_in(0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 1, 0, 8'd1)); // 6th enabled cycle
        add(mk_in(0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 1, 0, 8'd1)); // done ignored
        add(mk_in(1, 0, 0, 1, 0), mk_out(1, 0, 0, 1, 0, 0, 8'd0)); // clear beats start
        add(nop,                 mk_out(1, 0, 0, 0, 0, 0, 8'd0));
        add(mk_in(1, 1, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 8'd0)); // start beats step
        add(mk_in(0, 0, 0, 0, 1), mk_out(0, 0, 1, 0, 0, 0, 8'd1)); // RUN continues
        add(mk_in(0, 0, 1, 0, 1), mk_out(0, 0, 0, 0, 1, 0, 8'd2)); // halt with done
        add(mk_in(0, 0, 0, 1, 0), mk_out(1, 0, 0, 1, 0, 0, 8'd0));

        #1;
        do_reset("rst_init");

        foreach (tbl[k])
            cycle($sformatf("tbl%0d", k), tbl[k].i, tbl[k].o);

        // Instruction limit of 3, instr_done every 4th cycle.
        instr_limit = 8'd3;
        cycle("lim_start", mk_in(1, 0, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        for (int k = 1; k <= 3; k++) begin
            for (int j = 0; j < 3; j++)
                cycle($sformatf("lim%0d_w%0d", k, j), nop,
                      mk_out(0, 0, 1, 0, 0, 0, 8'(k - 1)));
            if (k < 3)
                cycle($sformatf("lim%0d_done", k), mk_in(0, 0, 0, 0, 1),
                      mk_out(0, 0, 1, 0, 0, 0, 8'(k)));
            else
                cycle("lim3_done", mk_in(0, 0, 0, 0, 1),
                      mk_out(0, 0, 0, 0, 1, 0, 8'd3));
        end
        cycle("lim_after", nop, mk_out(0, 0, 0, 0, 1, 0, 8'd3));
        cycle("lim_clear", mk_in(0, 0, 0, 1, 0), mk_out(1, 0, 0, 1, 0, 0, 8'd0));
        instr_limit = 8'd0;

        // halt_req mid-instruction completes the instruction first.
        cycle("hm_start", mk_in(1, 0, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        cycle("hm_req",   mk_in(0, 0, 1, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        cycle("hm_w0",    nop,                  mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        cycle("hm_w1",    nop,                  mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        cycle("hm_done",  mk_in(0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 1, 0, 8'd1));
        cycle("hm_clear", mk_in(0, 0, 0, 1, 0), mk_out(1, 0, 0, 1, 0, 0, 8'd0));

        // halt_req in IDLE is not remembered; then the watchdog fires.
        cycle("wd_idlehalt", mk_in(0, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 8'd0));
        cycle("wd_start",    mk_in(1, 0, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        cycle("wd_done",     mk_in(0, 0, 0, 0, 1), mk_out(0, 0, 1, 0, 0, 0, 8'd1));
        for (int j = 1; j < 16; j++)
            cycle($sformatf("wd_c%0d", j), nop, mk_out(0, 0, 1, 0, 0, 0, 8'd1));
        cycle("wd_c16",   nop,                  mk_out(0, 0, 0, 0, 0, 1, 8'd1));
        cycle("wd_start_ign", mk_in(1, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 1, 8'd1));
        cycle("wd_step_ign",  mk_in(0, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 1, 8'd1));
        cycle("wd_clear", mk_in(0, 0, 0, 1, 0), mk_out(1, 0, 0, 1, 0, 0, 8'd0));
        cycle("wd_idle",  nop,                  mk_out(1, 0, 0, 0, 0, 0, 8'd0));

        // instr_done on the 16th enabled cycle wins over the watchdog.
        cycle("wb_start", mk_in(1, 0, 0, 0, 0), mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        for (int j = 1; j < 16; j++)
            cycle($sformatf("wb_c%0d", j), nop, mk_out(0, 0, 1, 0, 0, 0, 8'd0));
        cycle("wb_c16", mk_in(0, 0, 0, 0, 1), mk_out(0, 0, 1, 0, 0, 0, 8'd1));
        for (int j = 0; j < 3; j++)
            cycle($sformatf("wb_run%0d", j), nop, mk_out(0, 0, 1, 0, 0, 0, 8'd1));

        // Reset mid-RUN, then during a mem_we cycle.
        do_reset("rst_run");
        cycle("rst_run_idle", nop, mk_out(1, 0, 0, 0, 0, 0, 8'd0));
        cycle("rst_we_ld", mk_ld(7, 8'hA5), mk_out(0, 1, 0, 0, 0, 0, 8'd0));
        do_reset("rst_we");
        for (int j = 0; j < 3; j++)
            cycle($sformatf("rst_we_after%0d", j), nop, mk_out(1, 0, 0, 0, 0, 0, 8'd0));

        n_cmp++;
        if (wr_q.size() != 0) begin
            n_bad++;
            $display("FAIL wr_queue: %0d expected writes never seen, want 0", wr_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
